// File: rtl/norm_exp_adjust_seq_if.sv
// Handshake and data bundle around the post-add normalizer.
// slave: the normalizer side, master: the upstream/downstream side.
interface norm_exp_adjust_seq_if #(
   parameter int SIZE_EXP = 8,
   parameter int SIZE_MAN = 24
);
   logic                i_valid;
   logic                o_ready;
   logic [SIZE_EXP-1:0] i_exp;
   logic [SIZE_MAN:0]   i_man;
   logic                o_valid;
   logic                i_ready;
   logic [SIZE_EXP-1:0] o_exp;
   logic [SIZE_MAN-1:0] o_man;
   logic                o_sticky;
   logic                o_zero;
   logic                o_overflow;
   logic                o_underflow;

   modport slave (
      input  i_valid, i_exp, i_man, i_ready,
      output o_ready, o_valid, o_exp, o_man, o_sticky, o_zero, o_overflow, o_underflow
   );

   modport master (
      output i_valid, i_exp, i_man, i_ready,
      input  o_ready, o_valid, o_exp, o_man, o_sticky, o_zero, o_overflow, o_underflow
   );
endinterface

// File: rtl/norm_exp_adjust_seq.sv
// Post-add normalizer: takes the raw sum mantissa (with carry) and the greater
// exponent, shifts back to normalized form one bit per cycle and adjusts the
// exponent. Flags zero, overflow and underflow (subnormal) results.
module norm_exp_adjust_seq #(
   parameter int SIZE_EXP = 8,
   parameter int SIZE_MAN = 24
) (
   input logic                  i_clk,
   input logic                  i_rst,
   norm_exp_adjust_seq_if.slave bus
);
   localparam logic [SIZE_EXP-1:0] ExpMax = '1;
   localparam logic [SIZE_EXP-1:0] ExpOne = SIZE_EXP'(1);

   typedef enum logic [1:0] {StIdle, StCheck, StShift, StDone} state_e;

   state_e              state_q, state_d;
   logic [SIZE_EXP-1:0] exp_q, exp_d;
   logic [SIZE_MAN:0]   man_q, man_d;
   logic [SIZE_EXP-1:0] res_exp_q, res_exp_d;
   logic [SIZE_MAN-1:0] res_man_q, res_man_d;
   logic                sticky_q, sticky_d;
   logic                zero_q, zero_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic [SIZE_MAN:0]   man_shl;
   logic [SIZE_EXP-1:0] exp_dec;
   logic [SIZE_EXP:0]   exp_inc;

   assign man_shl = {man_q[SIZE_MAN-1:0], 1'b0};
   assign exp_dec = exp_q - ExpOne;
   // One bit wider so the overflow compare cannot be fooled by a wrap.
   assign exp_inc = {1'b0, exp_q} + {{SIZE_EXP{1'b0}}, 1'b1};

   assign bus.o_ready     = (state_q == StIdle);
   assign bus.o_valid     = (state_q == StDone);
   assign bus.o_exp       = res_exp_q;
   assign bus.o_man       = res_man_q;
   assign bus.o_sticky    = sticky_q;
   assign bus.o_zero      = zero_q;
   assign bus.o_overflow  = ovf_q;
   assign bus.o_underflow = unf_q;

   // Next-state and result computation for the normalize FSM.
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      man_d     = man_q;
      res_exp_d = res_exp_q;
      res_man_d = res_man_q;
      sticky_d  = sticky_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      unique case (state_q)
         StIdle: begin
            if (bus.i_valid) begin
               // Subnormal operands carry exponent 0 but scale like exponent 1.
               exp_d   = (bus.i_exp == '0) ? ExpOne : bus.i_exp;
               man_d   = bus.i_man;
               state_d = StCheck;
            end
         end
         StCheck: begin
            state_d = StDone;
            if (man_q == '0) begin
               zero_d    = 1'b1;
               res_exp_d = '0;
               res_man_d = '0;
            end else if (man_q[SIZE_MAN]) begin
               if (exp_inc == {1'b0, ExpMax}) begin
                  ovf_d     = 1'b1;
                  res_exp_d = ExpMax;
                  res_man_d = '0;
               end else begin
                  res_exp_d = exp_inc[SIZE_EXP-1:0];
                  res_man_d = man_q[SIZE_MAN:1];
                  sticky_d  = man_q[0];
               end
            end else if (man_q[SIZE_MAN-1]) begin
               res_exp_d = exp_q;
               res_man_d = man_q[SIZE_MAN-1:0];
            end else begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (exp_q == ExpOne) begin
               // Already at the minimum exponent: no room to shift further.
               unf_d     = 1'b1;
               res_exp_d = '0;
               res_man_d = man_q[SIZE_MAN-1:0];
               state_d   = StDone;
            end else begin
               man_d = man_shl;
               exp_d = exp_dec;
               if (man_shl[SIZE_MAN-1]) begin
                  res_exp_d = exp_dec;
                  res_man_d = man_shl[SIZE_MAN-1:0];
                  state_d   = StDone;
               end else if (exp_dec == ExpOne) begin
                  unf_d     = 1'b1;
                  res_exp_d = '0;
                  res_man_d = man_shl[SIZE_MAN-1:0];
                  state_d   = StDone;
               end
            end
         end
         StDone: begin
            if (bus.i_ready) begin
               state_d   = StIdle;
               res_exp_d = '0;
               res_man_d = '0;
               sticky_d  = 1'b0;
               zero_d    = 1'b0;
               ovf_d     = 1'b0;
               unf_d     = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and result registers; async reset discards any in-flight result.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         exp_q     <= '0;
         man_q     <= '0;
         res_exp_q <= '0;
         res_man_q <= '0;
         sticky_q  <= 1'b0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         man_q     <= man_d;
         res_exp_q <= res_exp_d;
         res_man_q <= res_man_d;
         sticky_q  <= sticky_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end
endmodule

// File: tb/tb_norm_exp_adjust_seq.sv
// Randomized bench for norm_exp_adjust_seq against an arithmetic reference model.
module tb_norm_exp_adjust_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   norm_exp_adjust_seq_if bus ();

   norm_exp_adjust_seq dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]  e;
      logic [23:0] m;
      logic        s;
      logic        z;
      logic        o;
      logic        u;
      int          lat;
   } res_t;

   // Result from the normalization rules: leading-one position decides the shift count.
   function automatic res_t model(input logic [7:0] ei, input logic [24:0] mi);
      res_t        r;
      int          e;
      int          p;
      int          need;
      logic [24:0] t;
      r = '{e: 8'h0, m: 24'h0, s: 1'b0, z: 1'b0, o: 1'b0, u: 1'b0, lat: 2};
      e = (ei == 8'h0) ? 1 : int'(ei);
      if (mi == 25'h0) begin
         r.z = 1'b1;
      end else if (mi[24]) begin
         if (e + 1 == 255) begin
            r.o = 1'b1;
            r.e = 8'hFF;
         end else begin
            r.e = 8'(e + 1);
            r.m = mi[24:1];
            r.s = mi[0];
         end
      end else begin
         p = 0;
         for (int i = 0; i < 24; i++) if (mi[i]) p = i;
         need = 23 - p;
         if (e - need >= 1) begin
            t     = mi << need;
            r.e   = 8'(e - need);
            r.m   = t[23:0];
            r.lat = 2 + need;
         end else begin
            t     = mi << (e - 1);
            r.u   = 1'b1;
            r.e   = 8'h0;
            r.m   = t[23:0];
            r.lat = 2 + e - 1;
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_outputs(input string tag, input res_t r);
      chk({tag, "_exp"}, 32'(bus.o_exp), 32'(r.e));
      chk({tag, "_man"}, 32'(bus.o_man), 32'(r.m));
      chk({tag, "_flags"}, {28'h0, bus.o_sticky, bus.o_zero, bus.o_overflow, bus.o_underflow},
          {28'h0, r.s, r.z, r.o, r.u});
   endtask

   // One full transaction: accept, wait for result, optional backpressure, release.
   task automatic do_op(input logic [7:0] e, input logic [24:0] m, input int hold);
      res_t r;
      int   edges;
      r = model(e, m);
      @(negedge clk);
      chk("ready_before_accept", 32'(bus.o_ready), 32'd1);
      bus.i_valid = 1'b1;
      bus.i_exp   = e;
      bus.i_man   = m;
      bus.i_ready = 1'b0;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      while (!bus.o_valid && edges < 100) begin
         chk("ready_low_busy", 32'(bus.o_ready), 32'd0);
         bus.i_valid = 1'($urandom_range(0, 1));
         bus.i_exp   = 8'($urandom);
         bus.i_man   = 25'($urandom);
         bus.i_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      chk("latency", 32'(edges), 32'(r.lat));
      if (!bus.o_valid) return;
      chk_outputs("result", r);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", 32'(bus.o_valid), 32'd1);
         chk_outputs("hold", r);
      end
      bus.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_ready = 1'b0;
      chk("valid_cleared", 32'(bus.o_valid), 32'd0);
      chk("ready_after", 32'(bus.o_ready), 32'd1);
      chk_outputs("cleared", '{e: 8'h0, m: 24'h0, s: 1'b0, z: 1'b0, o: 1'b0, u: 1'b0, lat: 0});
   endtask

   initial begin
      res_t        r;
      logic [7:0]  e;
      logic [24:0] m;
      int          kind;
      bus.i_valid = 1'b1;
      bus.i_exp   = 8'h55;
      bus.i_man   = 25'h1234567;
      bus.i_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 32'(bus.o_valid), 32'd0);
      chk("reset_ready", 32'(bus.o_ready), 32'd1);
      chk_outputs("reset", '{e: 8'h0, m: 24'h0, s: 1'b0, z: 1'b0, o: 1'b0, u: 1'b0, lat: 0});
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      rst = 1'b0;

      // Hand-computed values pin the model.
      r = model(8'h80, 25'h0800000);
      chk("pin1", {r.e, r.m}, {8'h80, 24'h800000});
      r = model(8'h80, 25'h1000001);
      chk("pin2", {r.e, r.m[23:0]}, {8'h81, 24'h800000});
      chk("pin2_sticky", 32'(r.s), 32'd1);
      r = model(8'hFE, 25'h1000000);
      chk("pin3", {23'h0, r.o, r.e}, {23'h0, 1'b1, 8'hFF});
      r = model(8'h85, 25'h0000100);
      chk("pin4", {r.e, r.m}, {8'h76, 24'h800000});
      chk("pin4_lat", 32'(r.lat), 32'd17);
      r = model(8'h03, 25'h0000100);
      chk("pin5", {7'h0, r.u, r.e, r.m[15:0]}, {7'h0, 1'b1, 8'h00, 16'h0400});

      do_op(8'h80, 25'h0800000, 0);
      do_op(8'h80, 25'h1000001, 0);
      do_op(8'hFE, 25'h1000000, 0);
      do_op(8'h85, 25'h0000100, 0);
      do_op(8'h03, 25'h0000100, 0);
      do_op(8'h40, 25'h0000000, 5);
      do_op(8'h00, 25'h1000003, 1);

      // Reset during the shift phase of the long normalize case.
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_exp   = 8'h85;
      bus.i_man   = 25'h0000100;
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midreset_valid", 32'(bus.o_valid), 32'd0);
      chk_outputs("midreset", '{e: 8'h0, m: 24'h0, s: 1'b0, z: 1'b0, o: 1'b0, u: 1'b0, lat: 0});
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_ready", 32'(bus.o_ready), 32'd1);
      do_op(8'h85, 25'h0000100, 2);

      for (int n = 0; n < 200; n++) begin
         e    = 8'($urandom_range(2, 254));
         kind = $urandom_range(0, 15);
         if (kind == 0) m = 25'h0;
         else if (kind < 5) m = {1'b1, 24'($urandom)};
         else if (kind < 8) m = {2'b01, 23'($urandom)};
         else begin
            m = 25'($urandom) & 25'h0FFFFFF;
            m = m >> $urandom_range(1, 23);
            if (m == 25'h0) m = 25'h1;
         end
         do_op(e, m, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/norm_exp_adjust_seq.md
Name: norm_exp_adjust_seq

Overview:
Post-add normalizer for the FP adder datapath; the counterpart to exponent-difference alignment. Alignment moves mantissas right by the exponent difference. This block takes the raw sum mantissa, including the carry bit, and the greater exponent. It iteratively shifts the mantissa back to normalized form and adjusts the exponent. Results are flagged as zero, overflow or underflow. Sits between the mantissa SUM stage and the rounding/pack stage, with valid/ready handshakes on both sides.

Parameters:
SIZE_EXP, 8, exponent width
SIZE_MAN, 24, mantissa width including hidden bit; input mantissa is SIZE_MAN+1 bits (carry on MSB)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous reset, active-high
i_valid  input  1  input operand valid
o_ready  output  1  block can accept an operand (high only in IDLE)
i_exp  input  SIZE_EXP  greater exponent from alignment
i_man  input  SIZE_MAN+1  raw sum mantissa; bit SIZE_MAN = carry
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_exp  output  SIZE_EXP  adjusted exponent
o_man  output  SIZE_MAN  normalized mantissa; bit SIZE_MAN-1 = hidden bit
o_sticky  output  1  LSB lost on carry right-shift
o_zero  output  1  result is zero
o_overflow  output  1  exponent reached all-ones
o_underflow  output  1  result subnormal (o_exp=0, hidden bit 0)

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_valid, o_exp, o_man and all flags = 0. While i_rst=1, inputs are ignored.
- o_ready = (state==IDLE). Accept on the edge with i_valid && o_ready; latch i_exp and i_man. A latched exponent of 0 is treated as 1 (subnormal operands).
- FSM states: IDLE, CHECK, SHIFT, DONE.
- CHECK (one cycle), first matching rule wins:
  - man==0: o_zero=1, o_exp=0, o_man=0 -> DONE.
  - carry=1 and exp+1 == all-ones: o_overflow=1, o_exp=all-ones, o_man=0 -> DONE.
  - carry=1 otherwise: man >>= 1, exp += 1, o_sticky = shifted-out LSB -> DONE.
  - bit SIZE_MAN-1 set: -> DONE unchanged.
  - otherwise: -> SHIFT.
- SHIFT: one left shift per cycle, exp -= 1, zero fill.
  - Stop to DONE when bit SIZE_MAN-1 becomes 1, or when exp==1 with the hidden bit still 0.
  - In the second case: o_exp=0, o_underflow=1, mantissa left as shifted.
  - Exponent never decrements below 1 inside SHIFT.
- DONE: o_valid=1. Outputs are held stable until i_valid... until i_ready=1; on that edge go to IDLE, o_valid=0, flags cleared.
- Latency from the accept edge to o_valid high: 2 edges for the zero/carry/normalized cases; 2+k edges for k left shifts. k ≤ SIZE_MAN-1.
- Throughput: one operation in flight; no new accept until the return to IDLE.
- Reset asserted mid-operation in any state: immediate return to IDLE with cleared outputs; the in-flight result is discarded.
- Width rules: exponent arithmetic is unsigned SIZE_EXP bits and never wraps, because overflow and underflow are trapped above. The mantissa shift register is SIZE_MAN+1 bits; o_man is the low SIZE_MAN bits.

Test Plan:
1. Normalized pass-through: i_exp=0x80, i_man=0x0800000 -> o_exp=0x80, o_man=0x800000, all flags 0. o_valid 2 edges after accept.
2. Carry: i_exp=0x80, i_man=0x1000001 -> o_exp=0x81, o_man=0x800000, o_sticky=1, latency 2.
3. Overflow: i_exp=0xFE, i_man=0x1000000 -> o_overflow=1, o_exp=0xFF, o_man=0.
4. Left normalize: i_exp=0x85, i_man=0x0000100 -> 15 shifts; o_exp=0x76, o_man=0x800000, o_valid 17 edges after accept. o_ready stays low throughout.
5. Underflow: i_exp=0x03, i_man=0x0000100 -> 2 shifts; o_exp=0x00, o_man=0x000400, o_underflow=1.
6. Zero, backpressure and reset:
   - i_man=0 -> o_zero=1.
   - i_ready held low 5 cycles: o_valid and all outputs stable; IDLE only after i_ready=1.
   - i_rst pulsed during SHIFT of test 4: outputs immediately 0, o_ready=1 after release, next operation correct.
